spam1_cpu: RTL and testbench



---
 rtl/spam1_pkg.sv | 85 ++++++++
 rtl/spam1_alu.sv | 77 +++++++
 rtl/spam1_cpu.sv | 164 ++++++++++++++++
 tb/tb_spam1_cpu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spam1_pkg.sv
// Shared encodings for the spam1 CPU: instruction field positions, device and ALU enums, flag indices.
// Optional multiplier support is enabled with the SPAM1_MUL_EN macro (see spam1_alu).
package spam1_pkg;

    localparam int OP_MSB    = 47;
    localparam int OP_LSB    = 43;
    localparam int TDEV_MSB  = 42;
    localparam int TDEV_LSB  = 39;
    localparam int ADEV_MSB  = 38;
    localparam int ADEV_LSB  = 36;
    localparam int BDEV_MSB  = 35;
    localparam int BDEV_LSB  = 32;
    localparam int COND_MSB  = 31;
    localparam int COND_LSB  = 28;
    localparam int SETF_BIT  = 27;
    localparam int CINV_BIT  = 26;
    localparam int AMODE_BIT = 25;
    localparam int RSVD_BIT  = 24;
    localparam int ADDR_MSB  = 23;
    localparam int ADDR_LSB  = 8;
    localparam int IMM_MSB   = 7;
    localparam int IMM_LSB   = 0;

    // Flag register layout, czonENGL order from bit 0 upward
    localparam int F_C  = 0;
    localparam int F_Z  = 1;
    localparam int F_O  = 2;
    localparam int F_N  = 3;
    localparam int F_E  = 4;
    localparam int F_NE = 5;
    localparam int F_G  = 6;
    localparam int F_L  = 7;

    typedef enum logic [4:0] {
        OP_ZERO   = 5'd0,
        OP_A      = 5'd1,
        OP_B      = 5'd2,
        OP_NEG_A  = 5'd3,
        OP_NEG_B  = 5'd4,
        OP_INC_A  = 5'd5,
        OP_INC_B  = 5'd6,
        OP_DEC_A  = 5'd7,
        OP_DEC_B  = 5'd8,
        OP_ADD    = 5'd9,
        OP_SUB    = 5'd10,
        OP_RSUB   = 5'd11,
        OP_ADC    = 5'd12,
        OP_SBC    = 5'd13,
        OP_MUL_LO = 5'd14,
        OP_MUL_HI = 5'd15,
        OP_AND    = 5'd16,
        OP_OR     = 5'd17,
        OP_XOR    = 5'd18,
        OP_NOT_A  = 5'd19,
        OP_NOT_B  = 5'd20
    } alu_op_e;

    typedef enum logic [2:0] {
        AD_A = 3'd0, AD_B = 3'd1, AD_C = 3'd2, AD_D = 3'd3,
        AD_MARLO = 3'd4, AD_MARHI = 3'd5, AD_UART = 3'd6, AD_NONE = 3'd7
    } adev_e;

    typedef enum logic [3:0] {
        BD_A = 4'd0, BD_B = 4'd1, BD_C = 4'd2, BD_D = 4'd3,
        BD_MARLO = 4'd4, BD_MARHI = 4'd5, BD_IMM = 4'd6, BD_RAM = 4'd7
    } bdev_e;

    typedef enum logic [3:0] {
        TD_A = 4'd0, TD_B = 4'd1, TD_C = 4'd2, TD_D = 4'd3,
        TD_MARLO = 4'd4, TD_MARHI = 4'd5, TD_UART = 4'd6, TD_RAM = 4'd7,
        TD_PCHI = 4'd8, TD_PC = 4'd9
    } tdev_e;

    typedef enum logic [3:0] {
        CD_ALWAYS = 4'd0, CD_C = 4'd1, CD_Z = 4'd2, CD_O = 4'd3,
        CD_N = 4'd4, CD_E = 4'd5, CD_NE = 4'd6, CD_G = 4'd7,
        CD_L = 4'd8, CD_DI = 4'd9, CD_DO = 4'd10
    } cond_e;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

endpackage

// File: rtl/spam1_alu.sv
// Combinational 8-bit ALU with czonENGL flag generation.
// Ops 14/15 produce the unsigned product bytes only when SPAM1_MUL_EN is defined.
module spam1_alu
    import spam1_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    input  alu_op_e    op,
    output logic [7:0] result,
    output logic [7:0] flags
);

    logic [7:0] x;
    logic [7:0] y;
    logic       cin;
    logic       arith;
    logic       sub;
    logic [8:0] r9;
    logic       ovf;
`ifdef SPAM1_MUL_EN
    logic [15:0] prod;
    assign prod = {8'd0, a} * {8'd0, b};
`endif

    // Add/subtract ops share one 9-bit adder; bit 8 is carry-out or borrow
    always_comb begin
        x      = '0;
        y      = '0;
        cin    = 1'b0;
        arith  = 1'b0;
        sub    = 1'b0;
        result = '0;
        case (op)
            OP_A:      result = a;
            OP_B:      result = b;
            OP_NEG_A:  begin arith = 1'b1; sub = 1'b1; y = a; end
            OP_NEG_B:  begin arith = 1'b1; sub = 1'b1; y = b; end
            OP_INC_A:  begin arith = 1'b1; x = a; y = 8'd1; end
            OP_INC_B:  begin arith = 1'b1; x = b; y = 8'd1; end
            OP_DEC_A:  begin arith = 1'b1; sub = 1'b1; x = a; y = 8'd1; end
            OP_DEC_B:  begin arith = 1'b1; sub = 1'b1; x = b; y = 8'd1; end
            OP_ADD:    begin arith = 1'b1; x = a; y = b; end
            OP_SUB:    begin arith = 1'b1; sub = 1'b1; x = a; y = b; end
            OP_RSUB:   begin arith = 1'b1; sub = 1'b1; x = b; y = a; end
            OP_ADC:    begin arith = 1'b1; x = a; y = b; cin = carry_in; end
            OP_SBC:    begin arith = 1'b1; sub = 1'b1; x = a; y = b; cin = carry_in; end
`ifdef SPAM1_MUL_EN
            OP_MUL_LO: result = prod[7:0];
            OP_MUL_HI: result = prod[15:8];
`endif
            OP_AND:    result = a & b;
            OP_OR:     result = a | b;
            OP_XOR:    result = a ^ b;
            OP_NOT_A:  result = ~a;
            OP_NOT_B:  result = ~b;
            default:   result = '0;
        endcase
        r9 = sub ? ({1'b0, x} - {1'b0, y} - {8'd0, cin})
                 : ({1'b0, x} + {1'b0, y} + {8'd0, cin});
        if (arith) result = r9[7:0];
        ovf = arith && (sub ? (x[7] != y[7]) : (x[7] == y[7])) && (r9[7] != x[7]);
    end

    always_comb begin
        flags       = '0;
        flags[F_C]  = arith & r9[8];
        flags[F_Z]  = (result == 8'd0);
        flags[F_O]  = ovf;
        flags[F_N]  = result[7];
        flags[F_E]  = (a == b);
        flags[F_NE] = (a != b);
        flags[F_G]  = (a > b);
        flags[F_L]  = (a < b);
    end

endmodule

// File: rtl/spam1_cpu.sv
// spam1 two-phase microcoded CPU core: phase FSM, register file, bus decode and condition logic.
// Build option SPAM1_MUL_EN enables the multiply ops inside spam1_alu.
module spam1_cpu
    import spam1_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc_addr,
    input  logic [47:0] instr,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_read,
    input  logic        uart_tx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_write,
    output logic        phase_exec
);

    phase_e      phase;
    phase_e      phase_next;
    logic [47:0] ir;
    logic [15:0] pc;
    logic [7:0]  regs [4];
    logic [7:0]  marlo;
    logic [7:0]  marhi;
    logic [7:0]  pchitmp;
    logic [7:0]  flags;

    alu_op_e     op;
    tdev_e       tdev;
    adev_e       adev;
    bdev_e       bdev;
    cond_e       cond;
    logic        set_flags;
    logic        cond_inv;
    logic        amode;
    logic [15:0] direct;
    logic [7:0]  immed;
    logic        unused_rsvd;

    logic [7:0]  abus;
    logic [7:0]  bbus;
    logic [7:0]  result;
    logic [7:0]  alu_flags;
    logic        cond_true;
    logic        exec;

    assign op          = alu_op_e'(ir[OP_MSB:OP_LSB]);
    assign tdev        = tdev_e'(ir[TDEV_MSB:TDEV_LSB]);
    assign adev        = adev_e'(ir[ADEV_MSB:ADEV_LSB]);
    assign bdev        = bdev_e'(ir[BDEV_MSB:BDEV_LSB]);
    assign cond        = cond_e'(ir[COND_MSB:COND_LSB]);
    assign set_flags   = ir[SETF_BIT];
    assign cond_inv    = ir[CINV_BIT];
    assign amode       = ir[AMODE_BIT];
    assign direct      = ir[ADDR_MSB:ADDR_LSB];
    assign immed       = ir[IMM_MSB:IMM_LSB];
    assign unused_rsvd = ir[RSVD_BIT];

    assign pc_addr   = pc;
    assign ram_addr  = amode ? direct : {marhi, marlo};
    assign ram_wdata = result;
    assign uart_tx_data = result;

    always_comb begin
        abus = '0;
        case (adev)
            AD_A, AD_B, AD_C, AD_D: abus = regs[adev[1:0]];
            AD_MARLO:               abus = marlo;
            AD_MARHI:               abus = marhi;
            AD_UART:                abus = uart_rx_data;
            default:                abus = '0;
        endcase
    end

    always_comb begin
        bbus = '0;
        case (bdev)
            BD_A, BD_B, BD_C, BD_D: bbus = regs[bdev[1:0]];
            BD_MARLO:               bbus = marlo;
            BD_MARHI:               bbus = marhi;
            BD_IMM:                 bbus = immed;
            BD_RAM:                 bbus = ram_rdata;
            default:                bbus = '0;
        endcase
    end

    spam1_alu u_alu (
        .a        (abus),
        .b        (bbus),
        .carry_in (flags[F_C]),
        .op       (op),
        .result   (result),
        .flags    (alu_flags)
    );

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            CD_ALWAYS: cond_true = 1'b1;
            CD_C:      cond_true = flags[F_C];
            CD_Z:      cond_true = flags[F_Z];
            CD_O:      cond_true = flags[F_O];
            CD_N:      cond_true = flags[F_N];
            CD_E:      cond_true = flags[F_E];
            CD_NE:     cond_true = flags[F_NE];
            CD_G:      cond_true = flags[F_G];
            CD_L:      cond_true = flags[F_L];
            CD_DI:     cond_true = uart_rx_valid;
            CD_DO:     cond_true = uart_tx_ready;
            default:   cond_true = 1'b0;
        endcase
    end

    assign exec = (phase == PH_EXEC) && (cond_true ^ cond_inv);

    always_ff @(posedge clk) begin
        if (reset) phase <= PH_FETCH;
        else       phase <= phase_next;
    end

    always_comb begin
        phase_next = (phase == PH_FETCH) ? PH_EXEC : PH_FETCH;
    end

    // Strobes exist only in an executing execute cycle and never under reset
    always_comb begin
        phase_exec    = (phase == PH_EXEC);
        ram_we        = exec && !reset && (tdev == TD_RAM);
        uart_tx_write = exec && !reset && (tdev == TD_UART);
        uart_rx_read  = exec && !reset && (adev == AD_UART);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= '0;
            ir      <= '0;
            pchitmp <= '0;
            marlo   <= '0;
            marhi   <= '0;
            flags   <= '0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else if (phase == PH_FETCH) begin
            ir <= instr;
        end else begin
            if (exec) begin
                case (tdev)
                    TD_A, TD_B, TD_C, TD_D: regs[tdev[1:0]] <= result;
                    TD_MARLO:               marlo   <= result;
                    TD_MARHI:               marhi   <= result;
                    TD_PCHI:                pchitmp <= result;
                    default:                ;
                endcase
                if (set_flags) flags <= alu_flags;
            end
            pc <= (exec && tdev == TD_PC) ? {pchitmp, result} : pc + 16'd1;
        end
    end

endmodule

// File: tb/tb_spam1_cpu.sv
// Directed self-checking bench for spam1_cpu: each instruction is fed in its fetch
// cycle and outputs/state are sampled on the falling edge.
module tb_spam1_cpu;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_addr;
    logic [47:0] instr;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_read;
    logic        uart_tx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_write;
    logic        phase_exec;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int base;

    localparam logic [4:0] ZERO = 5'd0, PA = 5'd1, PB = 5'd2, ADD = 5'd9, SUB = 5'd10;
    localparam logic [3:0] T_A = 4'd0, T_C = 4'd2, T_D = 4'd3, T_MARLO = 4'd4, T_MARHI = 4'd5;
    localparam logic [3:0] T_UART = 4'd6, T_RAM = 4'd7, T_PCHI = 4'd8, T_PC = 4'd9, T_NONE = 4'd10;
    localparam logic [2:0] A_A = 3'd0, A_UART = 3'd6, A_NONE = 3'd7;
    localparam logic [3:0] B_B = 4'd1, B_IMM = 4'd6, B_RAM = 4'd7, B_NONE = 4'd8;
    localparam logic [3:0] C_ALW = 4'd0, C_Z = 4'd2, C_DI = 4'd9;

    spam1_cpu dut (
        .clk           (clk),
        .reset         (reset),
        .pc_addr       (pc_addr),
        .instr         (instr),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_rdata     (ram_rdata),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_read  (uart_rx_read),
        .uart_tx_ready (uart_tx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_write (uart_tx_write),
        .phase_exec    (phase_exec)
    );

    always #5 clk = ~clk;

    // Strobe widths: count the clock edges at which each strobe is high
    always @(posedge clk) begin
        if (ram_we)        we_cnt++;
        if (uart_rx_read)  rd_cnt++;
        if (uart_tx_write) wr_cnt++;
    end

    function automatic logic [47:0] mk(input logic [4:0] op, input logic [3:0] t,
                                       input logic [2:0] a, input logic [3:0] b,
                                       input logic [3:0] c, input logic sf, input logic inv,
                                       input logic am, input logic [15:0] addr,
                                       input logic [7:0] imm);
        return {op, t, a, b, c, sf, inv, am, 1'b0, addr, imm};
    endfunction

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present an instruction in the fetch cycle and stop at the execute-phase falling edge
    task automatic exec_begin(input logic [47:0] i);
        instr = i;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic exec_end();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input logic [47:0] i);
        exec_begin(i);
        exec_end();
    endtask

    initial begin
        reset = 1'b1;
        instr = '0;
        ram_rdata = 8'h00;
        uart_rx_data = 8'h00;
        uart_rx_valid = 1'b0;
        uart_tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_pc", pc_addr, 16'h0000);
        check("rst_phase", phase_exec, 1'b0);
        check("rst_strobes", {ram_we, uart_rx_read, uart_tx_write}, 3'b000);
        check("rst_regs", {dut.regs[0], dut.regs[1], dut.regs[2], dut.regs[3]}, 32'h0);
        reset = 1'b0;

        run(mk(PB, T_A, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h42));
        check("lda_imm_rega", dut.regs[0], 8'h42);
        check("lda_imm_pc", pc_addr, 16'h0001);

        run(mk(PB, T_PCHI, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h01));
        uart_rx_valid = 1'b0;
        run(mk(PB, T_PC, A_NONE, B_IMM, C_DI, 1'b0, 1'b1, 1'b0, 16'h0, 8'h23));
        check("jmp_taken_pc", pc_addr, 16'h0123);
        uart_rx_valid = 1'b1;
        run(mk(PB, T_PC, A_NONE, B_IMM, C_DI, 1'b0, 1'b1, 1'b0, 16'h0, 8'h23));
        check("jmp_skipped_pc", pc_addr, 16'h0124);

        uart_rx_data = 8'h31;
        base = rd_cnt;
        exec_begin(mk(PA, T_A, A_UART, B_NONE, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
        check("rx_read_high", uart_rx_read, 1'b1);
        exec_end();
        check("rx_read_low", uart_rx_read, 1'b0);
        check("rx_rega", dut.regs[0], 8'h31);
        check("rx_pulses", rd_cnt - base, 1);
        uart_rx_valid = 1'b0;

        uart_tx_ready = 1'b1;
        base = wr_cnt;
        exec_begin(mk(PA, T_UART, A_A, B_NONE, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
        check("tx_write_high", uart_tx_write, 1'b1);
        check("tx_data", uart_tx_data, 8'h31);
        exec_end();
        check("tx_pulses", wr_cnt - base, 1);

        run(mk(PB, T_A, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'hFF));
        run(mk(PB, 4'd1, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h01));
        exec_begin(mk(ADD, T_NONE, A_A, B_B, C_ALW, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
        check("add_result", ram_wdata, 8'h00);
        exec_end();
        check("add_flags", dut.flags, 8'h63);
        run(mk(PB, T_PC, A_NONE, B_IMM, C_Z, 1'b0, 1'b0, 1'b0, 16'h0, 8'h80));
        check("jz_taken_pc", pc_addr, 16'h0180);
        run(mk(PB, T_NONE, A_NONE, B_IMM, C_ALW, 1'b1, 1'b0, 1'b0, 16'h0, 8'h05));
        check("passb_flags", dut.flags, 8'hA0);
        run(mk(ADD, T_NONE, A_A, B_B, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
        check("add_noflags", dut.flags, 8'hA0);

        run(mk(PB, T_MARHI, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h12));
        run(mk(PB, T_MARLO, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h34));
        run(mk(PB, T_A, A_NONE, B_IMM, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h55));
        base = we_cnt;
        exec_begin(mk(PA, T_RAM, A_A, B_NONE, C_ALW, 1'b0, 1'b0, 1'b0, 16'hBEEF, 8'h00));
        check("ram_we_high", ram_we, 1'b1);
        check("ram_addr_mar", ram_addr, 16'h1234);
        check("ram_wdata", ram_wdata, 8'h55);
        exec_end();
        check("ram_we_low", ram_we, 1'b0);
        check("ram_we_pulses", we_cnt - base, 1);

        ram_rdata = 8'h77;
        exec_begin(mk(PB, T_C, A_NONE, B_RAM, C_ALW, 1'b0, 1'b0, 1'b1, 16'hBEEF, 8'h00));
        check("ram_addr_direct", ram_addr, 16'hBEEF);
        exec_end();
        check("ram_load_regc", dut.regs[2], 8'h77);

        run(mk(SUB, T_D, A_A, B_B, C_ALW, 1'b1, 1'b0, 1'b0, 16'h0, 8'h00));
        check("sub_regd", dut.regs[3], 8'h54);
        check("sub_flags", dut.flags, 8'h60);

        base = we_cnt;
        exec_begin(mk(PA, T_RAM, A_A, B_NONE, C_ALW, 1'b0, 1'b0, 1'b0, 16'h0, 8'h00));
        reset = 1'b1;
        #1;
        check("rst_gates_we", ram_we, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_pc", pc_addr, 16'h0000);
        check("midrst_phase", phase_exec, 1'b0);
        check("midrst_no_write", we_cnt - base, 0);
        check("midrst_rega", dut.regs[0], 8'h00);
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
